heap_sort_drain: RTL and testbench
==================================

Name: heap_sort_drain

Overview:
- Downstream stage of the heap-sort output function.
- Consumes the Maybe-wrapped sorted vector that the output function produces: bits [160:0] of its 195-bit output, i.e. a valid bit plus 5 x 32-bit signed elements.
- Captures one vector, then serialises it as one element per cycle onto a valid/ready stream, with a last marker and a completed-vector counter.
- Stalls upstream while draining; accepts the next vector in the same cycle the last element is taken.

Parameters:
- N, 5, elements per vector (N = heap size 6 minus the 1 element dropped by tail).
- W, 32, element width in bits, two's-complement signed.
- CW, 16, width of the completed-vector counter.

Ports:
- system1000  input  1  clock, rising edge.
- system1000_rst  input  1  asynchronous, active-high reset.
- in_maybe  input  N*W+1  bit [N*W] is the Just/Nothing tag (1 = Just). Bits [N*W-1:0] are the vector; element 0 occupies the MSBs [N*W-1:(N-1)*W], element N-1 occupies [W-1:0].
- in_ready  output  1  stage can capture in_maybe this cycle.
- out_data  output  W  current element.
- out_valid  output  1  out_data is valid.
- out_last  output  1  out_data is element N-1 of the current vector.
- out_ready  input  1  downstream accepts out_data.
- vec_count  output  CW  number of fully drained vectors, wraps modulo 2^CW.
- busy  output  1  high in DRAIN.

Behaviour:
- State registers:
  - state ∈ {IDLE, DRAIN};
  - buf[N] of W bits;
  - idx of ceil(log2 N) bits;
  - vec_count.
- Reset (async assert, sync deassert handled externally):
  - state = IDLE, idx = 0, buf = 0, vec_count = 0;
  - outputs: out_valid = 0, out_last = 0, out_data = 0, in_ready = 1, busy = 0.
- Accept: capture occurs when in_maybe[N*W] = 1 and in_ready = 1.
- in_ready (combinational):
  - IDLE: 1.
  - DRAIN: out_last & out_ready.
- in_maybe with tag 0 is ignored in every state. Payload bits are don't-care when tag = 0.
- IDLE:
  - On capture: load buf from the payload, set idx = 0, state -> DRAIN.
  - Otherwise remain in IDLE.
- DRAIN:
  - out_valid = 1, out_data = buf[idx], out_last = (idx == N-1). All are registered or derived from registers, never combinationally from in_maybe.
  - Handshake occurs when out_valid & out_ready.
    - If idx < N-1: idx++.
    - If idx = N-1: vec_count++ (wraps from 2^CW-1 to 0). Then, if a capture occurs in the same cycle, reload buf, set idx = 0 and stay in DRAIN (back-to-back, no bubble). Otherwise state -> IDLE and idx = 0.
  - No handshake (out_ready = 0): hold out_data, out_last, idx and buf stable; out_valid stays 1 (AXI-style: valid is never withdrawn).
- Latency and throughput:
  - Capture at edge t -> element 0 valid in the cycle after t.
  - Sustained throughput is 1 element per cycle, i.e. N cycles per vector with back-to-back input.
- Element order: emitted in vector index order 0..N-1, matching the sorted order produced upstream. No re-sorting or arithmetic is performed; data passes through bit-exact, including sign.
- out_data = 0 whenever out_valid = 0.
- Reset mid-drain: the partially drained vector is discarded, vec_count clears, and out_valid drops on reset assertion.

Test Plan:
- Reset, then drive in_maybe = {1'b1, 1, 2, 3, 4, 5} (32-bit each) with out_ready = 1. Required:
  - out_data = 1, 2, 3, 4, 5 on 5 consecutive cycles starting the cycle after capture;
  - out_last only on 5;
  - vec_count 0 -> 1;
  - in_ready low during elements 1..4.
- Signed passthrough: vector {-7, -1, 0, 0x7FFFFFFF, 0x80000000} -> emitted bit-exact in order; out_data = 0xFFFFFFF9 first.
- Backpressure: out_ready low for 3 cycles while element 2 is presented -> out_data stays 2, out_valid stays 1, idx unchanged. Completion is delayed by exactly 3 cycles.
- Back-to-back: second vector {10, 20, 30, 40, 50} held valid throughout the first drain. Required:
  - captured on the cycle element 5 is accepted;
  - element 10 is emitted the next cycle with no gap;
  - vec_count ends at 2.
- Nothing tag: in_maybe[160] = 0 with a nonzero payload, in IDLE and at last-element accept -> no capture; the stage returns to or stays in IDLE and vec_count is unchanged.
- Async reset asserted after element 3 of a drain -> out_valid = 0, vec_count = 0, in_ready = 1 immediately (no clock edge needed). A new vector after deassert drains from element 0.

Source files
------------

// File: rtl/heap_sort_drain.sv
// rtl/heap_sort_drain.sv - captures a Maybe-wrapped sorted vector and drains it one element per cycle
module heap_sort_drain #(
    parameter int N  = 5,
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic           system1000,
    input  logic           system1000_rst,
    input  logic [N*W:0]   in_maybe,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    output logic           out_last,
    input  logic           out_ready,
    output logic [CW-1:0]  vec_count,
    output logic           busy
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [W-1:0]   r_buf [N];
    logic [IW-1:0]  r_idx;
    logic [CW-1:0]  r_vec_count;

    logic           w_tag;
    logic           w_at_last;
    logic           w_handshake;
    logic           w_vec_done;
    logic           w_capture;

    // Upstream may only load a new vector when idle or while the final
    // element is being taken, so back-to-back vectors leave no bubble.
    assign w_tag       = in_maybe[N*W];
    assign w_at_last   = (r_state == S_DRAIN) && (r_idx == LAST_IDX);
    assign w_handshake = (r_state == S_DRAIN) && out_ready;
    assign w_vec_done  = w_handshake && w_at_last;
    assign in_ready    = (r_state == S_IDLE) || (w_at_last && out_ready);
    assign w_capture   = w_tag && in_ready;
    assign vec_count   = r_vec_count;

    // State register
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: enter DRAIN on capture, leave only when the last element goes without a reload
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_capture) w_next_state = S_DRAIN;
            S_DRAIN: if (w_vec_done && !w_capture) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs derive only from registers so nothing leaks from in_maybe to the stream
    always_comb begin
        out_valid = (r_state == S_DRAIN);
        out_last  = w_at_last;
        busy      = (r_state == S_DRAIN);
        out_data  = '0;
        if (r_state == S_DRAIN) begin
            out_data = r_buf[r_idx];
        end
    end

    // Vector buffer: element 0 sits in the payload MSBs
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= in_maybe[(N-1-i)*W +: W];
            end
        end
    end

    // Element index: restarts on capture or after the last element, holds under backpressure
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            r_idx <= '0;
        end else if (w_capture) begin
            r_idx <= '0;
        end else if (w_handshake) begin
            r_idx <= w_at_last ? '0 : r_idx + 1'b1;
        end
    end

    // Completed-vector counter, wraps naturally
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            r_vec_count <= '0;
        end else if (w_vec_done) begin
            r_vec_count <= r_vec_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_heap_sort_drain.sv
// tb/tb_heap_sort_drain.sv - self-checking bench for heap_sort_drain
module tb_heap_sort_drain;
    localparam int N  = 5;
    localparam int W  = 32;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W:0]   in_maybe = '0;
    logic           out_ready = 1'b0;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic [CW-1:0]  vec_count;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    heap_sort_drain #(.N(N), .W(W), .CW(CW)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .in_maybe       (in_maybe),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .vec_count      (vec_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W:0] pack(input logic tag, input logic [W-1:0] e0, e1, e2, e3, e4);
        return {tag, e0, e1, e2, e3, e4};
    endfunction

    function automatic logic [35:0] obs();
        return {out_valid, out_last, in_ready, busy, out_data};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_maybe = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_tests++;
        if ({obs(), vec_count} !== {4'b0010, 32'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", {obs(), vec_count}, {4'b0010, 32'd0, 16'd0});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        @(negedge clk);
        in_maybe = pack(1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_idle_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        in_maybe[N*W] = 1'b0;
        for (int k = 0; k < N; k++) begin
            #1;
            n_tests++;
            if ({obs(), vec_count} !== {1'b1, k == 4, k == 4, 1'b1, 32'(k + 1), 16'd0}) begin
                n_fail++;
                $display("FAIL basic_elem%0d got=%h exp=%h", k, {obs(), vec_count},
                         {1'b1, k == 4, k == 4, 1'b1, 32'(k + 1), 16'd0});
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if ({obs(), vec_count} !== {4'b0010, 32'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL basic_done got=%h exp=%h", {obs(), vec_count}, {4'b0010, 32'd0, 16'd1});
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] ev [N];
        ev[0] = 32'hFFFF_FFF9;
        ev[1] = 32'hFFFF_FFFF;
        ev[2] = 32'h0000_0000;
        ev[3] = 32'h7FFF_FFFF;
        ev[4] = 32'h8000_0000;
        do_reset();
        @(negedge clk);
        in_maybe = pack(1'b1, ev[0], ev[1], ev[2], ev[3], ev[4]);
        out_ready = 1'b1;
        @(negedge clk);
        in_maybe[N*W] = 1'b0;
        for (int k = 0; k < N; k++) begin
            #1;
            n_tests++;
            if ({out_valid, out_data} !== {1'b1, ev[k]}) begin
                n_fail++;
                $display("FAIL signed_elem%0d got=%h exp=%h", k, {out_valid, out_data}, {1'b1, ev[k]});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ed [8];
        ed[0] = 1; ed[1] = 2; ed[2] = 2; ed[3] = 2; ed[4] = 2; ed[5] = 3; ed[6] = 4; ed[7] = 5;
        do_reset();
        @(negedge clk);
        in_maybe = pack(1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        out_ready = 1'b1;
        @(negedge clk);
        in_maybe[N*W] = 1'b0;
        for (int c = 0; c < 9; c++) begin
            out_ready = !(c >= 1 && c <= 3);
            #1;
            n_tests++;
            if (c < 8) begin
                if ({obs(), vec_count} !== {1'b1, c == 7, c == 7, 1'b1, ed[c], 16'd0}) begin
                    n_fail++;
                    $display("FAIL backpressure_c%0d got=%h exp=%h", c, {obs(), vec_count},
                             {1'b1, c == 7, c == 7, 1'b1, ed[c], 16'd0});
                end
            end else if ({obs(), vec_count} !== {4'b0010, 32'd0, 16'd1}) begin
                n_fail++;
                $display("FAIL backpressure_done got=%h exp=%h", {obs(), vec_count}, {4'b0010, 32'd0, 16'd1});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        in_maybe = pack(1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        out_ready = 1'b1;
        @(negedge clk);
        in_maybe = pack(1'b1, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50);
        for (int c = 0; c < 11; c++) begin
            if (c == 5) in_maybe[N*W] = 1'b0;
            #1;
            n_tests++;
            if (c < 10) begin
                if ({obs(), vec_count} !== {1'b1, c % 5 == 4, c % 5 == 4, 1'b1,
                                            (c < 5) ? 32'(c + 1) : 32'((c - 4) * 10), 16'(c / 5)}) begin
                    n_fail++;
                    $display("FAIL b2b_c%0d got=%h exp=%h", c, {obs(), vec_count},
                             {1'b1, c % 5 == 4, c % 5 == 4, 1'b1,
                              (c < 5) ? 32'(c + 1) : 32'((c - 4) * 10), 16'(c / 5)});
                end
            end else if ({obs(), vec_count} !== {4'b0010, 32'd0, 16'd2}) begin
                n_fail++;
                $display("FAIL b2b_done got=%h exp=%h", {obs(), vec_count}, {4'b0010, 32'd0, 16'd2});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_nothing();
        do_reset();
        @(negedge clk);
        in_maybe = pack(1'b0, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if ({obs(), vec_count} !== {4'b0010, 32'd0, 16'd0}) begin
                n_fail++;
                $display("FAIL nothing_idle_c%0d got=%h exp=%h", c, {obs(), vec_count}, {4'b0010, 32'd0, 16'd0});
            end
            @(negedge clk);
        end
        in_maybe = pack(1'b1, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1);
        @(negedge clk);
        in_maybe = pack(1'b0, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7);
        for (int c = 0; c < 7; c++) begin
            #1;
            n_tests++;
            if (c < 5) begin
                if ({obs(), vec_count} !== {1'b1, c == 4, c == 4, 1'b1, 32'(5 - c), 16'd0}) begin
                    n_fail++;
                    $display("FAIL nothing_drain_c%0d got=%h exp=%h", c, {obs(), vec_count},
                             {1'b1, c == 4, c == 4, 1'b1, 32'(5 - c), 16'd0});
                end
            end else if ({obs(), vec_count} !== {4'b0010, 32'd0, 16'd1}) begin
                n_fail++;
                $display("FAIL nothing_after_c%0d got=%h exp=%h", c, {obs(), vec_count}, {4'b0010, 32'd0, 16'd1});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        in_maybe = pack(1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        out_ready = 1'b1;
        @(negedge clk);
        in_maybe = pack(1'b1, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15);
        repeat (5) @(negedge clk);
        in_maybe[N*W] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_data, vec_count} !== {1'b1, 32'd14, 16'd1}) begin
            n_fail++;
            $display("FAIL areset_pre got=%h exp=%h", {out_valid, out_data, vec_count}, {1'b1, 32'd14, 16'd1});
        end
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({obs(), vec_count} !== {4'b0010, 32'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL areset_immediate got=%h exp=%h", {obs(), vec_count}, {4'b0010, 32'd0, 16'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        in_maybe = pack(1'b1, 32'd21, 32'd22, 32'd23, 32'd24, 32'd25);
        @(negedge clk);
        in_maybe[N*W] = 1'b0;
        #1;
        n_tests++;
        if ({obs(), vec_count} !== {4'b1001, 32'd21, 16'd0}) begin
            n_fail++;
            $display("FAIL areset_restart got=%h exp=%h", {obs(), vec_count}, {4'b1001, 32'd21, 16'd0});
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q [$];
        int           cnt;
        logic         e_valid, e_last, e_ready;
        logic [W-1:0] e_data;
        logic [N*W:0] v;
        do_reset();
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) v[i*W +: W] = $urandom();
            v[N*W] = ($urandom_range(0, 9) < 6);
            in_maybe = v;
            #1;
            e_valid = (q.size() > 0);
            e_last  = (q.size() == 1);
            e_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
            e_data  = e_valid ? q[0] : '0;
            n_tests++;
            if ({obs(), vec_count} !== {e_valid, e_last, e_ready, e_valid, e_data, 16'(cnt)}) begin
                n_fail++;
                $display("FAIL random_c%0d got=%h exp=%h", c, {obs(), vec_count},
                         {e_valid, e_last, e_ready, e_valid, e_data, 16'(cnt)});
            end
            if (e_valid && out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) cnt++;
            end
            if (v[N*W] && e_ready) begin
                for (int i = 0; i < N; i++) q.push_back(v[(N-1-i)*W +: W]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_back_to_back();
        test_nothing();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
